// File: rtl/matmul_operand_loader.sv
// Operand loader for the matrix-multiply core.
// Takes operand bytes over a valid/ready handshake and presents them to the core one
// element at a time on input_val/sel_in. Each element is held for HOLD_CYCLES cycles.
// After N_ELEM elements it strobes execute for EXEC_CYCLES cycles, then pulses done.
//
// state   | meaning
// WAIT    | ready for the next operand byte (in_ready high)
// HOLD    | current element held stable on input_val/sel_in
// EXEC    | all elements loaded, execute strobe high
// DONE    | one-cycle completion pulse, job state cleared on exit
module matmul_operand_loader #(
    parameter int DATA_W      = 8,
    parameter int N_ELEM      = 8,
    parameter int SEL_W       = 3,
    parameter int HOLD_CYCLES = 2,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] input_val,
    output logic [SEL_W-1:0]  sel_in,
    output logic              execute,
    output logic              busy,
    output logic              done,
    output logic [SEL_W:0]    elem_count
);

    // One shared down-counter times both the hold and the execute phases.
    localparam int CNT_MAX = (HOLD_CYCLES > EXEC_CYCLES) ? HOLD_CYCLES : EXEC_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_HOLD = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] idx;
    logic             xfer;
    logic             cnt_zero;
    logic             last_elem;

    // Ready depends only on state; it is held low while reset is asserted.
    assign in_ready  = (state == ST_WAIT) && !reset;
    assign xfer      = in_valid && in_ready;
    assign cnt_zero  = (cnt == '0);
    assign last_elem = (idx == SEL_W'(N_ELEM - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode; abort overrides every transition.
    always_comb begin
        state_nxt = state;
        execute   = 1'b0;
        done      = 1'b0;
        case (state)
            ST_WAIT: begin
                if (xfer) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_nxt = last_elem ? ST_EXEC : ST_WAIT;
                end
            end
            ST_EXEC: begin
                execute = 1'b1;
                if (cnt_zero) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_WAIT;
            end
            default: state_nxt = ST_WAIT;
        endcase
        if (abort) begin
            state_nxt = ST_WAIT;
        end
    end

    // Datapath: operand capture, element index, phase timer and job status.
    // input_val/sel_in are only cleared by reset, never by abort or job completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            input_val  <= '0;
            sel_in     <= '0;
            elem_count <= '0;
            busy       <= 1'b0;
        end else if (abort) begin
            cnt        <= '0;
            idx        <= '0;
            elem_count <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (xfer) begin
                        input_val  <= in_data;
                        sel_in     <= idx;
                        elem_count <= {1'b0, idx} + 1'b1;
                        busy       <= 1'b1;
                        cnt        <= CNT_W'(HOLD_CYCLES - 1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_zero) begin
                        if (last_elem) begin
                            cnt <= CNT_W'(EXEC_CYCLES - 1);
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    busy       <= 1'b0;
                    idx        <= '0;
                    elem_count <= '0;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule
